issue_unit: RTL
===============

# issue_unit

In-order issue stage of the Tomasulo core, sitting between the fetch queue and the reservation stations (RS) / reorder buffer (ROB). It buffers one fetched instruction and decodes it with the existing `decoder` block. It classifies the instruction to a functional unit and dispatches it only when the target RS and the ROB both have a free entry. It also detects illegal opcodes, handles pipeline flush, and keeps issue/stall performance counters.

## Interface
Parameters:
- `ROB_TAG_W`, 3: width of ROB tag.
- `CNT_W`, 32: width of performance counters.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  mispredict/exception flush from commit.
- `if_valid`  in  1  fetch offers an instruction.
- `if_ready`  out  1  issue unit accepts the instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  instruction PC.
- `alu_rs_free`, `lsu_rs_free`, `br_rs_free`  in  1 each  target RS has a free entry.
- `rob_free`  in  1  ROB has a free entry.
- `rob_tag`  in  ROB_TAG_W  tag the ROB will assign on allocation.
- `iss_valid`  out  1  dispatch fires this cycle; also serves as ROB allocate strobe.
- `iss_unit`  out  2  0=ALU, 1=LSU, 2=BR.
- `iss_opcode`  out  7  decoded opcode.
- `iss_funct3`  out  3  decoded funct3.
- `iss_funct7`  out  7  decoded funct7.
- `iss_rs1`, `iss_rs2`, `iss_rd`  out  5 each  decoded register indices.
- `iss_imm`  out  32  decoded immediate.
- `iss_imm_type`  out  2  decoded immediate type.
- `iss_pc`  out  32  PC of the issued instruction.
- `iss_tag`  out  ROB_TAG_W  equal to `rob_tag` when `iss_valid` is high.
- `trap`  out  1  illegal instruction held.
- `trap_pc`  out  32  PC of the illegal instruction.
- `issue_cnt`  out  CNT_W  number of dispatched instructions.
- `stall_cnt`  out  CNT_W  number of resource-stall cycles.

## Operation
- States: IDLE (buffer empty), HOLD (buffer valid), TRAP (illegal held).
- `if_ready` = !flush && (IDLE || (HOLD && fire)). It is never high in TRAP.
- Capture: on `if_valid && if_ready`, latch `if_instr` and `if_pc` into the buffer, then go to HOLD.
- The decoder is combinational on the buffered word. All `iss_*` fields come from the buffer.
- Unit classification by opcode:
  - ALU: 0110011, 0010011, 0110111, 0010111.
  - LSU: 0000011, 0100011.
  - BR: 1100011, 1101111, 1100111.
  - Any other opcode is illegal.
- `fire` = HOLD && legal && free flag of the target unit && `rob_free` && !flush. `iss_valid` = `fire`.
- HOLD transitions:
  - fire with a simultaneous capture: stay in HOLD with the new word.
  - fire with no capture: go to IDLE.
  - no fire and legal: stay in HOLD.
  - illegal: go to TRAP; `trap_pc` ← buffered PC.
- TRAP: `trap`=1, no issue, no accept. Exit only via flush or rst.
- Flush has priority over everything:
  - No fire and no capture in that cycle.
  - Next state IDLE, `trap` cleared.
  - Counters are not affected.
- `issue_cnt` increments on every fire.
- `stall_cnt` increments on every cycle that is HOLD, legal, not fire, and not flush.
- Both counters wrap modulo 2^CNT_W.
- When `iss_valid`=0, the `iss_*` fields are don't-care but must be stable (driven from the buffer, no X).

## Timing
- Reset values:
  - State IDLE, buffer cleared to 0.
  - `if_ready`=1 once `rst` is low.
  - `iss_valid`=0, `trap`=0, `trap_pc`=0.
  - `issue_cnt`=0, `stall_cnt`=0.
- Reset mid-operation discards the buffered instruction. No issue occurs in the reset cycle.
- Latency: a word captured at edge N can fire at the earliest in cycle N+1, where `iss_valid` is combinational.
- Throughput: 1 instruction per cycle with resources free, using the simultaneous fire-and-capture path.
- Resource flags and `rob_tag` are sampled combinationally in the fire cycle. RS and ROB capture on the same edge.
- A trap becomes visible the cycle after the illegal word was captured into HOLD.

## Test plan
- Reset: hold `rst` 2 cycles -> all outputs at reset values; `if_ready`=1 the cycle after release.
- Back-to-back issue: stream `addi x1,x2,10` (0x00A10093), then `add x1,x2,x3` (0x003100B3), all resources free, `rob_tag`=5 ->
  - `iss_valid` high 2 consecutive cycles.
  - First issue: `iss_unit`=0, `iss_imm`=10, `iss_tag`=5.
  - `issue_cnt`=2.
- Stall: `sw x3,4(x2)` (0x00312223) with `lsu_rs_free`=0 for 3 cycles ->
  - `if_ready`=0 and `stall_cnt`=3.
  - Then issues with `iss_unit`=1 and `iss_imm`=4.
- ROB full: `beq` with `br_rs_free`=1 and `rob_free`=0 -> no issue; issue follows the cycle after `rob_free` rises, with `iss_unit`=2.
- Illegal: word 0x0000007F at PC 0x100 -> `trap`=1 and `trap_pc`=0x100, `if_ready`=0 indefinitely; `flush` -> IDLE and `trap`=0.
- Flush in the fire cycle: HOLD with resources free and `flush`=1 -> `iss_valid`=0, `issue_cnt` unchanged, state IDLE next cycle.

Source files
------------

// File: rtl/issue_unit.sv
// In-order issue stage: buffers one fetched instruction, decodes it, and dispatches
// it to the ALU/LSU/BR reservation station once that RS and the ROB have room.
module issue_unit #(
    parameter int ROB_TAG_W = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [31:0]          if_instr,
    input  logic [31:0]          if_pc,
    input  logic                 alu_rs_free,
    input  logic                 lsu_rs_free,
    input  logic                 br_rs_free,
    input  logic                 rob_free,
    input  logic [ROB_TAG_W-1:0] rob_tag,
    output logic                 iss_valid,
    output logic [1:0]           iss_unit,
    output logic [6:0]           iss_opcode,
    output logic [2:0]           iss_funct3,
    output logic [6:0]           iss_funct7,
    output logic [4:0]           iss_rs1,
    output logic [4:0]           iss_rs2,
    output logic [4:0]           iss_rd,
    output logic [31:0]          iss_imm,
    output logic [1:0]           iss_imm_type,
    output logic [31:0]          iss_pc,
    output logic [ROB_TAG_W-1:0] iss_tag,
    output logic                 trap,
    output logic [31:0]          trap_pc,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] TRAP = 2'd2;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_LSU = 2'd1;
    localparam logic [1:0] UNIT_BR  = 2'd2;

    // Immediate format encoding; U and J share a code since only two bits exist.
    localparam logic [1:0] IMM_I  = 2'd0;
    localparam logic [1:0] IMM_S  = 2'd1;
    localparam logic [1:0] IMM_B  = 2'd2;
    localparam logic [1:0] IMM_UJ = 2'd3;

    logic [1:0]  state;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        legal;
    logic        unit_free;
    logic        fire;
    logic        capture;

    assign iss_opcode = buf_instr[6:0];
    assign iss_rd     = buf_instr[11:7];
    assign iss_funct3 = buf_instr[14:12];
    assign iss_rs1    = buf_instr[19:15];
    assign iss_rs2    = buf_instr[24:20];
    assign iss_funct7 = buf_instr[31:25];
    assign iss_pc     = buf_pc;
    assign iss_tag    = rob_tag;

    always_comb begin
        legal        = 1'b1;
        iss_unit     = UNIT_ALU;
        iss_imm_type = IMM_I;
        iss_imm      = 32'd0;
        case (buf_instr[6:0])
            7'b0110011: begin
                iss_unit = UNIT_ALU;
            end
            7'b0010011: begin
                iss_unit = UNIT_ALU;
                iss_imm  = {{20{buf_instr[31]}}, buf_instr[31:20]};
            end
            7'b0110111, 7'b0010111: begin
                iss_unit     = UNIT_ALU;
                iss_imm_type = IMM_UJ;
                iss_imm      = {buf_instr[31:12], 12'd0};
            end
            7'b0000011: begin
                iss_unit = UNIT_LSU;
                iss_imm  = {{20{buf_instr[31]}}, buf_instr[31:20]};
            end
            7'b0100011: begin
                iss_unit     = UNIT_LSU;
                iss_imm_type = IMM_S;
                iss_imm      = {{20{buf_instr[31]}}, buf_instr[31:25], buf_instr[11:7]};
            end
            7'b1100011: begin
                iss_unit     = UNIT_BR;
                iss_imm_type = IMM_B;
                iss_imm      = {{20{buf_instr[31]}}, buf_instr[7], buf_instr[30:25],
                                buf_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                iss_unit     = UNIT_BR;
                iss_imm_type = IMM_UJ;
                iss_imm      = {{12{buf_instr[31]}}, buf_instr[19:12], buf_instr[20],
                                buf_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                iss_unit = UNIT_BR;
                iss_imm  = {{20{buf_instr[31]}}, buf_instr[31:20]};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (iss_unit)
            UNIT_ALU: unit_free = alu_rs_free;
            UNIT_LSU: unit_free = lsu_rs_free;
            UNIT_BR:  unit_free = br_rs_free;
            default:  unit_free = 1'b0;
        endcase
    end

    assign fire      = (state == HOLD) && legal && unit_free && rob_free && !flush;
    assign iss_valid = fire;
    assign if_ready  = !flush && ((state == IDLE) || ((state == HOLD) && fire));
    assign capture   = if_valid && if_ready;
    assign trap      = (state == TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
            trap_pc   <= 32'd0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        buf_instr <= if_instr;
                        buf_pc    <= if_pc;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!legal) begin
                        state   <= TRAP;
                        trap_pc <= buf_pc;
                    end else if (fire) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (capture) begin
                            buf_instr <= if_instr;
                            buf_pc    <= if_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                TRAP: state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
